// File: rtl/sfifo_pkg.sv
// Shared constants for the watermark FIFO: watermark state encoding and
// the bit positions of the interrupt enable mask.
package sfifo_pkg;

    // Watermark state encoding (kept as plain constants for legacy tools).
    localparam logic [0:0] WM_BELOW = 1'b0;
    localparam logic [0:0] WM_ABOVE = 1'b1;

    // Bit positions inside i_int_en = {underflow, overflow, watermark}.
    localparam int INT_WMARK = 0;
    localparam int INT_OVF   = 1;
    localparam int INT_UNF   = 2;

endpackage

// File: rtl/sfifo_watermark_if.sv
// Write/read handshake bundle of the watermark FIFO. The FIFO takes the
// slave side; whoever pushes and pops data takes the master side.
interface sfifo_watermark_if #(
    parameter int BW     = 8,
    parameter int LGFLEN = 4
);
    logic              i_wr;
    logic [BW-1:0]     i_data;
    logic              o_full;
    logic [LGFLEN:0]   o_fill;
    logic              i_rd;
    logic [BW-1:0]     o_data;
    logic              o_empty;

    modport master (
        output i_wr, i_data, i_rd,
        input  o_full, o_fill, o_data, o_empty
    );

    modport slave (
        input  i_wr, i_data, i_rd,
        output o_full, o_fill, o_data, o_empty
    );
endinterface

// File: rtl/sfifo_wmark_mem.sv
// Storage for the watermark FIFO: register array with a synchronous write
// port and an asynchronous (combinational) read port.
module sfifo_wmark_mem #(
    parameter int BW     = 8,
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [LGFLEN-1:0] i_waddr,
    input  logic [BW-1:0]     i_wdata,
    input  logic [LGFLEN-1:0] i_raddr,
    output logic [BW-1:0]     o_rdata
);
    logic [BW-1:0] mem [1 << LGFLEN];

    // Synchronous write of one entry.
    // NOTE: the array has no reset; contents are only meaningful once the
    // pointers say so, and a reset here would turn the array into flops with
    // a reset tree for no functional gain.
    always_ff @(posedge i_clk) begin
        if (i_we)
            mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/sfifo_watermark.sv
// Synchronous FIFO with fill level, hysteretic watermark, sticky
// overflow/underflow flags and a registered masked interrupt.
module sfifo_watermark
    import sfifo_pkg::*;
#(
    parameter int BW     = 8,
    parameter int LGFLEN = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    sfifo_watermark_if.slave    bus,
    input  logic [LGFLEN:0]     i_high_thresh,
    input  logic [LGFLEN:0]     i_low_thresh,
    input  logic [2:0]          i_int_en,
    input  logic                i_clr_err,
    output logic                o_wmark,
    output logic                o_overflow,
    output logic                o_underflow,
    output logic                o_int
);
    localparam logic [LGFLEN:0] FULL_FILL = {1'b1, {LGFLEN{1'b0}}};

    logic [LGFLEN-1:0] wr_ptr, rd_ptr;
    logic [LGFLEN:0]   fill_q, nf;
    logic              full_q, empty_q;
    logic [0:0]        wm_state, wm_next;
    logic              ovf_next, unf_next;
    logic              w_wr, w_rd;

    // A write into a full FIFO is refused even if a read frees a slot in
    // the same cycle; this keeps the full flag a pure registered decision.
    assign w_wr = bus.i_wr && !full_q;
    assign w_rd = bus.i_rd && !empty_q;

    assign bus.o_fill  = fill_q;
    assign bus.o_full  = full_q;
    assign bus.o_empty = empty_q;
    assign o_wmark     = (wm_state == WM_ABOVE);

    // The array has no reset, so a write coinciding with reset is blocked
    // here to keep storage consistent with the cleared pointers.
    sfifo_wmark_mem #(
        .BW     (BW),
        .LGFLEN (LGFLEN)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_wr && !i_reset),
        .i_waddr (wr_ptr),
        .i_wdata (bus.i_data),
        .i_raddr (rd_ptr),
        .o_rdata (bus.o_data)
    );

    // Next fill level from this cycle's accepted operations.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        nf = fill_q;
        if (w_wr && !w_rd)
            nf = fill_q + 1'b1;
        else if (!w_wr && w_rd)
            nf = fill_q - 1'b1;
    end

    // Watermark next state: hysteresis, with set winning when the
    // thresholds overlap.
    always_comb begin
        wm_next = wm_state;
        if (i_low_thresh >= i_high_thresh)
            wm_next = (nf >= i_high_thresh) ? WM_ABOVE : WM_BELOW;
        else if (wm_state == WM_BELOW && nf >= i_high_thresh)
            wm_next = WM_ABOVE;
        else if (wm_state == WM_ABOVE && nf <= i_low_thresh)
            wm_next = WM_BELOW;
    end

    // Sticky error flags: a new error in the clear cycle keeps the flag set.
    assign ovf_next = (bus.i_wr && full_q)  || (o_overflow  && !i_clr_err);
    assign unf_next = (bus.i_rd && empty_q) || (o_underflow && !i_clr_err);

    // Pointers, fill and status flags, all registered from nf.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (w_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (w_rd)
                rd_ptr <= rd_ptr + 1'b1;
            fill_q  <= nf;
            full_q  <= (nf == FULL_FILL);
            empty_q <= (nf == '0);
        end
    end

    // Watermark state, error flags and the interrupt aligned with them.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wm_state    <= WM_BELOW;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            o_int       <= 1'b0;
        end else begin
            wm_state    <= wm_next;
            o_overflow  <= ovf_next;
            o_underflow <= unf_next;
            o_int       <= (i_int_en[INT_WMARK] && (wm_next == WM_ABOVE))
                         | (i_int_en[INT_OVF]   && ovf_next)
                         | (i_int_en[INT_UNF]   && unf_next);
        end
    end
endmodule

// File: tb/tb_sfifo_watermark.sv
// Directed bench for sfifo_watermark (BW=8, LGFLEN=4).
module tb_sfifo_watermark;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] high_thresh, low_thresh;
    logic [2:0] int_en;
    logic       clr_err;
    logic       wmark, ovf, unf, irq;
    int         passed = 0;
    int         total  = 0;

    sfifo_watermark_if #(.BW(8), .LGFLEN(4)) bus ();

    sfifo_watermark #(.BW(8), .LGFLEN(4)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .bus           (bus.slave),
        .i_high_thresh (high_thresh),
        .i_low_thresh  (low_thresh),
        .i_int_en      (int_en),
        .i_clr_err     (clr_err),
        .o_wmark       (wmark),
        .o_overflow    (ovf),
        .o_underflow   (unf),
        .o_int         (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fill"},  32'(bus.o_fill), 0);
        check({tag, "_empty"}, 32'(bus.o_empty), 1);
        check({tag, "_full"},  32'(bus.o_full), 0);
        check({tag, "_wmark"}, 32'(wmark), 0);
        check({tag, "_ovf"},   32'(ovf), 0);
        check({tag, "_unf"},   32'(unf), 0);
        check({tag, "_int"},   32'(irq), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_wr = 1'b0; bus.i_rd = 1'b0; bus.i_data = '0;
        high_thresh = 5'd12; low_thresh = 5'd4; int_en = 3'b111; clr_err = 1'b0;
        #1;
        check_reset_values("por");
        tick();
        rst = 1'b0;

        // Underflow on empty, clear blocked by a concurrent bad read.
        bus.i_rd = 1'b1;
        tick();
        check("unf_set", 32'(unf), 1);
        check("unf_fill", 32'(bus.o_fill), 0);
        check("unf_empty", 32'(bus.o_empty), 1);
        check("unf_int", 32'(irq), 1);
        clr_err = 1'b1;
        tick();
        check("unf_clr_vs_set", 32'(unf), 1);
        bus.i_rd = 1'b0;
        tick();
        clr_err = 1'b0;
        check("unf_cleared", 32'(unf), 0);
        check("unf_int_clr", 32'(irq), 0);

        // Fill to full with 0x00..0x0F; watermark sets at 12.
        bus.i_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.i_data = 8'(i);
            tick();
            check("wr_fill", 32'(bus.o_fill), i + 1);
            if (i == 0) begin
                check("first_not_empty", 32'(bus.o_empty), 0);
                check("first_data", 32'(bus.o_data), 32'h00);
            end
            if (i == 10) check("wmark_at11", 32'(wmark), 0);
            if (i == 11) check("wmark_at12", 32'(wmark), 1);
        end
        check("full_set", 32'(bus.o_full), 1);
        bus.i_data = 8'hAA;
        tick();
        bus.i_wr = 1'b0;
        check("ovf_fill", 32'(bus.o_fill), 16);
        check("ovf_full", 32'(bus.o_full), 1);
        check("ovf_set", 32'(ovf), 1);
        check("ovf_int", 32'(irq), 1);

        // Read back in order; watermark holds at 5, clears at 4.
        for (int i = 0; i < 16; i++) begin
            check("rd_data", 32'(bus.o_data), i);
            bus.i_rd = 1'b1;
            tick();
            if (i == 10) check("wmark_at5", 32'(wmark), 1);
            if (i == 11) check("wmark_at4", 32'(wmark), 0);
        end
        bus.i_rd = 1'b0;
        check("drain_empty", 32'(bus.o_empty), 1);
        check("drain_fill", 32'(bus.o_fill), 0);
        check("drain_int_ovf", 32'(irq), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_cleared", 32'(ovf), 0);
        check("int_cleared", 32'(irq), 0);

        // Fill to 8, then 20 cycles of simultaneous write and read.
        bus.i_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.i_data = 8'(32'h20 + i);
            tick();
        end
        bus.i_rd = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.i_data = 8'(32'h28 + k);
            check("stream_data", 32'(bus.o_data), 32'h20 + k);
            tick();
            check("stream_fill", 32'(bus.o_fill), 8);
        end
        bus.i_rd = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.i_data = 8'(32'h3C + k);
            tick();
        end
        bus.i_data = 8'hEE;
        tick();
        bus.i_wr = 1'b0;
        check("refill_full", 32'(bus.o_full), 1);
        check("refill_ovf", 32'(ovf), 1);
        for (int k = 0; k < 6; k++) begin
            check("wrap_data", 32'(bus.o_data), 32'h34 + k);
            bus.i_rd = 1'b1;
            tick();
        end
        bus.i_rd = 1'b0;
        check("pre_rst_fill", 32'(bus.o_fill), 10);
        check("pre_rst_wmark", 32'(wmark), 1);
        check("pre_rst_int", 32'(irq), 1);

        // Asynchronous reset mid-stream, with a write pending.
        bus.i_wr = 1'b1;
        bus.i_data = 8'h55;
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("async");
        tick();
        rst = 1'b0;
        bus.i_wr = 1'b0;
        tick();
        check("rst_wr_discard_fill", 32'(bus.o_fill), 0);
        check("rst_wr_discard_empty", 32'(bus.o_empty), 1);

        // Mask only the watermark; full-write with a same-cycle read.
        int_en = 3'b001;
        bus.i_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.i_data = 8'(32'h60 + i);
            tick();
        end
        check("m_full", 32'(bus.o_full), 1);
        check("m_head", 32'(bus.o_data), 32'h60);
        bus.i_rd = 1'b1;
        bus.i_data = 8'hBB;
        tick();
        bus.i_wr = 1'b0;
        bus.i_rd = 1'b0;
        check("m_rej_fill", 32'(bus.o_fill), 15);
        check("m_rej_next", 32'(bus.o_data), 32'h61);
        check("m_ovf", 32'(ovf), 1);
        check("m_int_wm", 32'(irq), 1);
        bus.i_rd = 1'b1;
        for (int k = 0; k < 11; k++) tick();
        bus.i_rd = 1'b0;
        check("m_fill4", 32'(bus.o_fill), 4);
        check("m_wmark0", 32'(wmark), 0);
        check("m_ovf_held", 32'(ovf), 1);
        check("m_int_masked", 32'(irq), 0);

        // Overlapping thresholds: set wins, no hysteresis.
        high_thresh = 5'd6;
        low_thresh  = 5'd8;
        tick();
        check("ov_wm_4", 32'(wmark), 0);
        bus.i_wr = 1'b1;
        bus.i_data = 8'h11;
        tick();
        tick();
        bus.i_wr = 1'b0;
        check("ov_fill6", 32'(bus.o_fill), 6);
        check("ov_wm_6", 32'(wmark), 1);
        bus.i_rd = 1'b1;
        tick();
        bus.i_rd = 1'b0;
        check("ov_wm_5", 32'(wmark), 0);
        high_thresh = 5'd0;
        low_thresh  = 5'd0;
        tick();
        check("hi0_wm", 32'(wmark), 1);
        check("hi0_int", 32'(irq), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sfifo_watermark.md
SFIFO_WATERMARK -- requirements
Module: sfifo_watermark

Interface
REQ-001 Parameter BW, default 8, data width in bits.
REQ-002 Parameter LGFLEN, default 4, log2 of depth; FLEN = 2^LGFLEN entries.
REQ-003 i_clk  input  1  sole clock, all state on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_wr  input  1  write request.
REQ-006 i_data  input  BW  write data.
REQ-007 o_full  output  1  FIFO holds FLEN entries.
REQ-008 o_fill  output  LGFLEN+1  current entry count, 0..FLEN.
REQ-009 i_rd  input  1  read request; o_data is consumed when the read is accepted.
REQ-010 o_data  output  BW  oldest entry; combinational from storage; valid while !o_empty.
REQ-011 o_empty  output  1  FIFO holds 0 entries.
REQ-012 i_high_thresh  input  LGFLEN+1  set level for watermark.
REQ-013 i_low_thresh  input  LGFLEN+1  clear level for watermark.
REQ-014 i_int_en  input  3  interrupt mask {underflow, overflow, watermark}.
REQ-015 i_clr_err  input  1  one-cycle pulse clearing sticky error flags.
REQ-016 o_wmark  output  1  hysteretic watermark state.
REQ-017 o_overflow  output  1  sticky overflow flag.
REQ-018 o_underflow  output  1  sticky underflow flag.
REQ-019 o_int  output  1  registered masked interrupt.

Function
REQ-020 Accepted write w_wr = i_wr && !o_full; accepted read w_rd = i_rd && !o_empty; a write when full SHALL be rejected even if a read is accepted in the same cycle.
REQ-021 Fill update: +1 on w_wr only, -1 on w_rd only, unchanged on both or neither; o_full/o_empty registered and consistent with o_fill every cycle.
REQ-022 Pointers are LGFLEN bits wide, wrap modulo FLEN; data written at wr_ptr, read at rd_ptr; first-in first-out order preserved across wrap.
REQ-023 Write into empty FIFO: o_empty deasserts the next cycle, and o_data shows the written word in that cycle.
REQ-024 Next fill nf is computed from the current cycle's accepted operations; all flags below are registered from nf and the current-cycle inputs.
REQ-025 Watermark FSM states BELOW/ABOVE: BELOW->ABOVE when nf >= i_high_thresh; ABOVE->BELOW when nf <= i_low_thresh; otherwise hold; o_wmark = (state == ABOVE).
REQ-026 If i_low_thresh >= i_high_thresh, set SHALL win: o_wmark = (nf >= i_high_thresh).
REQ-027 Threshold comparisons are unsigned over LGFLEN+1 bits; i_high_thresh = 0 forces ABOVE; values above FLEN never set.
REQ-028 o_overflow sets on i_wr && o_full; o_underflow sets on i_rd && o_empty; both hold until i_clr_err; set wins over a same-cycle clear.
REQ-029 o_int <= (en[0] & next o_wmark) | (en[1] & next o_overflow) | (en[2] & next o_underflow), so o_int is aligned with the flags it reflects.
REQ-030 Rejected operations SHALL NOT change pointers, fill or storage.

Reset
REQ-031 i_reset asserted SHALL, without waiting for a clock edge, clear pointers, o_fill=0, o_empty=1, o_full=0, o_wmark=0 (BELOW), o_overflow=0, o_underflow=0, o_int=0.
REQ-032 Storage contents are not reset; reset during a write SHALL discard that write.

Structure
REQ-033 The watermark state encoding and the interrupt-mask bit indices SHALL live in a shared package sfifo_pkg.
REQ-034 Storage SHALL be a single sub-module sfifo_wmark_mem (register array, synchronous write, asynchronous read); control, FSM and flags stay in the top module.

Verification (BW=8, LGFLEN=4, high=12, low=4, int_en=3'b111 unless stated)
REQ-035 Write 16 words 0x00..0x0F, then one more -> o_full=1, o_fill=16, 17th write rejected, o_overflow=1, o_int=1; reading back yields 0x00..0x0F in order.
REQ-036 Fill to 12 -> o_wmark=1 on the cycle o_fill=12; read down to 5 -> o_wmark stays 1; read to 4 -> o_wmark=0.
REQ-037 Read while empty -> o_underflow=1, o_fill stays 0; i_clr_err with i_rd still asserted on empty -> flag stays 1; clr_err alone -> 0.
REQ-038 At fill 8, simultaneous i_wr and i_rd for 20 cycles -> o_fill stays 8, pointers wrap, data order intact.
REQ-039 Assert i_reset mid-stream at fill 10 with o_overflow=1 -> all outputs reach their reset values immediately, before the next clock edge.
REQ-040 int_en=3'b001, force overflow -> o_overflow=1 while o_int follows o_wmark only.
